// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display path.
package seven_seg_pkg;

    // Active-low "everything off" levels for the segment bus and anode strobes.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by hex value 0..F.
    localparam logic [0:15][6:0] HEX_SEG_TABLE = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Per-slot scan phase: anodes dark during BLANK, active digit lit during DRIVE.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure table lookup, no registers.
    always_comb begin
        seg = HEX_SEG_TABLE[hex];
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with per-slot blanking and
// frame-synchronous double-buffered digit data.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  digit_en_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start,
    output logic        upd_pending
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
    // With no blanking the slot never leaves DRIVE.
    localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
        $fatal(1, "seven_seg_scan_ctrl: need REFRESH_DIV >= 2 and 0 <= BLANK_CYCLES < REFRESH_DIV");
    end

    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      idx, idx_n;
    scan_state_t     state, state_n;
    logic            wrap, xfer;
    logic [3:0][3:0] pend_digits, shad_digits, shad_digits_n;
    logic [3:0]      pend_en, shad_en, shad_en_n;
    logic            upd_pending_n;
    logic [3:0]      dec_hex;
    logic [6:0]      dec_seg;
    logic [3:0]      an_n;
    logic [6:0]      seg_n;

    // Next slot position, scan phase and shadow contents; the load/transfer
    // collision forwards the incoming value straight into the shadow copy.
    always_comb begin
        wrap          = (cnt == LAST);
        cnt_n         = wrap ? '0 : cnt + 1'b1;
        idx_n         = wrap ? idx + 2'd1 : idx;
        xfer          = wrap && (idx == 2'd3);

        state_n = state;
        case (state)
            BLANK:   if (cnt_n == BLANK_C) state_n = DRIVE;
            DRIVE:   if (wrap) state_n = SLOT_START;
            default: state_n = SLOT_START;
        endcase

        shad_digits_n = shad_digits;
        shad_en_n     = shad_en;
        if (xfer) begin
            shad_digits_n = load ? digits_in : pend_digits;
            shad_en_n     = load ? digit_en_in : pend_en;
        end

        upd_pending_n = upd_pending;
        if (xfer) begin
            upd_pending_n = 1'b0;
        end else if (load) begin
            upd_pending_n = 1'b1;
        end

        dec_hex = shad_digits_n[idx_n];
    end

    hex_to_seg u_hex_to_seg (
        .hex (dec_hex),
        .seg (dec_seg)
    );

    // Output levels for the upcoming cycle, so pins line up with cnt/idx.
    always_comb begin
        an_n  = AN_OFF;
        seg_n = SEG_OFF;
        if (state_n == DRIVE && shad_en_n[idx_n]) begin
            an_n[idx_n] = 1'b0;
            seg_n       = dec_seg;
        end
    end

    // Scan position, buffers and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            state       <= SLOT_START;
            pend_digits <= '0;
            pend_en     <= '0;
            shad_digits <= '0;
            shad_en     <= '0;
            upd_pending <= 1'b0;
            frame_start <= 1'b1;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
        end else begin
            cnt         <= cnt_n;
            idx         <= idx_n;
            state       <= state_n;
            if (load) begin
                pend_digits <= digits_in;
                pend_en     <= digit_en_in;
            end
            shad_digits <= shad_digits_n;
            shad_en     <= shad_en_n;
            upd_pending <= upd_pending_n;
            frame_start <= xfer;
            an          <= an_n;
            seg         <= seg_n;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  digit_en_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;
    logic        upd_pending;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Segment patterns of digits 4,3,2,1 (slots 0..3 of 16'h1234).
    logic [6:0] f2_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    seven_seg_scan_ctrl #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .digits_in   (digits_in),
        .digit_en_in (digit_en_in),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start),
        .upd_pending (upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) next_cycle();
    endtask

    initial begin
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int lows [4];
        int slot, off, base;

        rst = 1'b1;
        load = 1'b0;
        digits_in = '0;
        digit_en_in = '0;

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_upd", upd_pending, 1'b0);
        check("rst_fs", frame_start, 1'b1);
        rst = 1'b0;
        cyc = 0;

        for (int c = 1; c < 5; c++) begin
            next_cycle();
            check("dark_an", an, 4'hF);
            check("fs_low", frame_start, 1'b0);
        end

        // Load 1234 at cycle 5.
        next_cycle();
        load = 1'b1; digits_in = 16'h1234; digit_en_in = 4'hF;
        check("upd_before_load", upd_pending, 1'b0);
        next_cycle();
        load = 1'b0;
        check("upd_set", upd_pending, 1'b1);
        run_to(31);
        check("upd_hold", upd_pending, 1'b1);
        check("an_dark_f1", an, 4'hF);
        check("fs_31", frame_start, 1'b0);
        next_cycle();
        check("fs_32", frame_start, 1'b1);
        check("upd_clr", upd_pending, 1'b0);

        // Frame 2 scan: cycles 32..63.
        for (int c = 32; c < 64; c++) begin
            if (c > 32) next_cycle();
            slot = (c - 32) / 8;
            off  = (c - 32) % 8;
            exp_an = 4'hF;
            exp_seg = 7'h7F;
            if (off >= 2) begin
                exp_an[slot] = 1'b0;
                exp_seg = f2_seg[slot];
            end
            check("f2_an", an, exp_an);
            check("f2_seg", seg, exp_seg);
        end
        next_cycle();
        check("fs_64", frame_start, 1'b1);

        // Masking: digits 8888, enables 0101, loaded at cycle 70.
        run_to(70);
        load = 1'b1; digits_in = 16'h8888; digit_en_in = 4'b0101;
        next_cycle();
        load = 1'b0;
        run_to(96);
        check("fs_96", frame_start, 1'b1);
        for (int i = 0; i < 4; i++) lows[i] = 0;
        for (int c = 96; c < 128; c++) begin
            if (c > 96) next_cycle();
            check("mask_onehot", ($countones(~an) <= 1), 1'b1);
            for (int i = 0; i < 4; i++) if (!an[i]) lows[i]++;
            if (an != 4'hF) check("mask_seg", seg, 7'b0000000);
            else check("mask_seg_off", seg, 7'h7F);
        end
        check("mask_low0", lows[0], 6);
        check("mask_low1", lows[1], 0);
        check("mask_low2", lows[2], 6);
        check("mask_low3", lows[3], 0);

        // Last write wins: AAAA at 138, 0F0F at 148.
        run_to(138);
        load = 1'b1; digits_in = 16'hAAAA; digit_en_in = 4'hF;
        next_cycle();
        load = 1'b0;
        check("lww_upd1", upd_pending, 1'b1);
        run_to(148);
        load = 1'b1; digits_in = 16'h0F0F; digit_en_in = 4'hF;
        next_cycle();
        load = 1'b0;
        check("lww_upd2", upd_pending, 1'b1);
        run_to(160);
        check("fs_160", frame_start, 1'b1);
        run_to(162);
        check("lww_an0", an, 4'b1110);
        check("lww_seg0", seg, 7'b0001110);
        run_to(170);
        check("lww_an1", an, 4'b1101);
        check("lww_seg1", seg, 7'b1000000);
        run_to(178);
        check("lww_an2", an, 4'b1011);
        check("lww_seg2", seg, 7'b0001110);
        run_to(186);
        check("lww_an3", an, 4'b0111);
        check("lww_seg3", seg, 7'b1000000);

        // Bypass: load on the transfer-edge cycle 191.
        run_to(191);
        load = 1'b1; digits_in = 16'hC6B9; digit_en_in = 4'hF;
        check("byp_upd_191", upd_pending, 1'b0);
        next_cycle();
        load = 1'b0;
        check("fs_192", frame_start, 1'b1);
        for (int c = 192; c < 203; c++) begin
            if (c > 192) next_cycle();
            check("byp_upd", upd_pending, 1'b0);
            if (c == 194) begin
                check("byp_an0", an, 4'b1110);
                check("byp_seg0", seg, 7'b0010000);
            end
            if (c == 202) begin
                check("byp_an1", an, 4'b1101);
                check("byp_seg1", seg, 7'b0000011);
            end
        end

        // Mid-frame reset with a pending load.
        run_to(203);
        load = 1'b1; digits_in = 16'hEEEE; digit_en_in = 4'hF;
        next_cycle();
        load = 1'b0;
        check("mr_upd", upd_pending, 1'b1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("mr_an", an, 4'hF);
        check("mr_seg", seg, 7'h7F);
        check("mr_upd_clr", upd_pending, 1'b0);
        check("mr_fs", frame_start, 1'b1);
        base = cyc;
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            check("mr_dark", an, 4'hF);
            check("mr_upd_low", upd_pending, 1'b0);
            check("mr_fs_seq", frame_start, (c % 32) == 0);
        end
        check("mr_elapsed", cyc - base, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing scheduler for the board's shared 4-digit seven-segment driver. It owns the single `seg` bus and the four `an` strobes and gives each digit a fixed refresh slot in turn. It inserts a blanking gap at the start of each slot to prevent ghosting. Digit data is double-buffered so that updates only take effect at a frame boundary, which prevents tearing. It sits between the top-level logic that produces hex/BCD values and the board pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all anodes off; legal range 0 ≤ `BLANK_CYCLES` < `REFRESH_DIV`.
- `clk` in 1: single system clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: one-cycle strobe that captures `digits_in` and `digit_en_in`.
- `digits_in` in 16: four hex nibbles; `[3:0]` maps to `an[0]` (rightmost), `[15:12]` maps to `an[3]`.
- `digit_en_in` in 4: per-digit enable; 0 means the digit stays dark during its slot.
- `an` out 4: anode strobes, active-low, at most one low at a time.
- `seg` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `frame_start` out 1: one-cycle pulse in the first cycle of digit-0's slot.
- `upd_pending` out 1: high while a loaded value waits for the next frame boundary.

## Operation
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1, then wraps.
  - On wrap, digit index `idx` advances 0→1→2→3→0.
  - One frame = 4·`REFRESH_DIV` cycles.
- Per-slot FSM states:
  - BLANK while `cnt` < `BLANK_CYCLES`.
  - DRIVE while `cnt` ≥ `BLANK_CYCLES`.
  - BLANK→DRIVE when `cnt` reaches `BLANK_CYCLES`.
  - DRIVE→BLANK on wrap.
  - With `BLANK_CYCLES`=0, BLANK is never entered.
- In BLANK: `an`=4'b1111 and `seg`=7'b1111111.
- In DRIVE:
  - `an[idx]`=0 only if `shadow_en[idx]`=1; otherwise `an`=4'b1111.
  - `seg` = decoded hex of the `shadow_digits` nibble for `idx`.
  - `seg` is all-off when the digit is disabled.
- Hex decode examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
- Buffering:
  - `load` writes the pending registers and sets `upd_pending`.
  - Repeated loads before a transfer: last write wins.
  - Transfer pending→shadow occurs on the edge entering `cnt`=0, `idx`=0 (the `frame_start` cycle). `upd_pending` clears on the same edge.
  - If `load` coincides with the transfer edge, the newly loaded value bypasses directly to shadow and `upd_pending` stays 0.
- Reset values:
  - `cnt`=0, `idx`=0, state BLANK (DRIVE if `BLANK_CYCLES`=0).
  - Pending and shadow digits = 0; pending and shadow enables = 0, so the display is dark.
  - `upd_pending`=0, `an`=4'b1111, `seg`=7'b1111111.
  - `frame_start`=1 in the first cycle after reset.
- Reset mid-frame returns to reset values on the next edge; any pending data is discarded.

## Timing
- `an` and `seg` are registered, computed from next-state values, so they align exactly with `cnt`/`idx`. The active digit's anode is low for precisely `REFRESH_DIV`-`BLANK_CYCLES` cycles per slot.
- `seg` changes only at the BLANK boundary, never while any anode is low, provided `BLANK_CYCLES` ≥ 1.
- Load-to-display latency:
  - From the cycle after `load` to the next `frame_start` cycle: between 1 and 4·`REFRESH_DIV` cycles.
  - 0 cycles when the bypass case applies.
- `frame_start` is registered and high exactly in the cycles where `cnt`=0 and `idx`=0.
- `cnt` width is `$clog2(REFRESH_DIV)`; no other arithmetic.

## Structure
- Package `seven_seg_pkg`:
  - 16-entry active-low hex segment table constant.
  - `SEG_OFF`=7'h7F and `AN_OFF`=4'hF constants.
  - FSM state enum {BLANK, DRIVE}.
- One natural sub-module, `hex_to_seg`: 4-bit in, 7-bit active-low out, combinational, table from the package. It is shared with other display users.
- Parameter legality is checked by an elaboration-time assertion.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2, so one frame is 32 cycles.
- Reset behaviour: hold `rst` 3 cycles → `an`=1111, `seg`=1111111, `upd_pending`=0; after release, `frame_start` is high in cycle 0 and again every 32 cycles; `an` stays 1111 throughout, since enables are 0.
- Load and scan: `load` with `digits_in`=16'h1234, `digit_en_in`=4'hF at cycle 5 → `upd_pending`=1 for cycles 6–31. In frame 2:
  - `an`=1110, `seg`=0011001 (4) for cycles 34–39.
  - `an`=1101, `seg`=0110000 (3) for cycles 42–47.
  - `an`=1111 during cycles 32–33 and 40–41.
- Masking: `digit_en_in`=4'b0101 with digits 16'h8888 → only `an[0]` and `an[2]` ever go low. The `an[1]` and `an[3]` slots still last 8 cycles dark.
- Last-write-wins and bypass: loads of 16'hAAAA at cycle 10 and 16'h0F0F at cycle 20 → frame 2 shows 0F0F. A further `load` in cycle 63 (the transfer edge) → displayed from cycle 64 with `upd_pending` never rising.
- Mid-frame reset: assert `rst` at cycle 45 with a pending load → next cycle all outputs are at reset values; after release the display is dark and `upd_pending`=0.
